// File: rtl/i281_bios_pkg.sv
// Shared definitions for the loadable BIOS instruction bank: reload FSM
// state encoding, default geometry and the modular checksum helper.
package i281_bios_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } bank_state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 16;

    // Running checksum step: (a + b) mod 2^width, for widths up to 64 bits.
    function automatic logic [63:0] csum_add(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input int          width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (a + b) & mask;
    endfunction

endpackage

// File: rtl/bios_bank_mem.sv
// DEPTH x WIDTH instruction register array: async clear to zero, one
// write port, one registered read port with read-before-write behaviour.
module bios_bank_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage and read register; the read samples the pre-write contents.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            o_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/bios_loadable_bank.sv
// Loadable BIOS instruction bank: registered fetch port plus a valid/ready
// reload stream closed by a checksum beat. Define BIOS_LOCK_EN to make the
// bank write-once per reset (load_start ignored after the first DONE).
module bios_loadable_bank
    import i281_bios_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             load_start,
    input  logic             load_abort,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    output logic             bank_valid,
    output logic             load_busy,
    output logic             load_err
);

    bank_state_t      r_state;
    logic [AW-1:0]    r_wr_ptr;
    logic [WIDTH-1:0] r_sum;
    logic             r_bank_valid;
    logic             r_load_err;

    logic             w_ready;
    logic             w_beat;
    logic             w_start;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_sum_next;

    assign w_ready    = (r_state == LOAD) || (r_state == CHECK);
    assign w_beat     = ld_valid & w_ready;
    assign w_wr_en    = (r_state == LOAD) & w_beat & ~load_abort;
    assign w_sum_next = WIDTH'(csum_add(64'(r_sum), 64'(ld_data), WIDTH));

`ifdef BIOS_LOCK_EN
    logic r_locked;

    assign w_start = load_start & ~r_locked;

    // Lock latch: set on the first successful checksum, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_locked <= 1'b0;
        end else if (r_state == CHECK && w_beat && !load_abort && ld_data == r_sum) begin
            r_locked <= 1'b1;
        end
    end
`else
    assign w_start = load_start;
`endif

    // Reload FSM with write pointer, running checksum and status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_sum        <= '0;
            r_bank_valid <= 1'b1;
            r_load_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_state      <= LOAD;
                        r_wr_ptr     <= '0;
                        r_sum        <= '0;
                        r_bank_valid <= 1'b0;
                        r_load_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        r_state      <= IDLE;
                        r_load_err   <= 1'b1;
                        r_bank_valid <= 1'b0;
                    end else if (w_beat) begin
                        r_sum    <= w_sum_next;
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                        if (r_wr_ptr == AW'(DEPTH - 1)) begin
                            r_state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (load_abort) begin
                        r_state      <= IDLE;
                        r_load_err   <= 1'b1;
                        r_bank_valid <= 1'b0;
                    end else if (w_beat) begin
                        if (ld_data == r_sum) begin
                            r_bank_valid <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_load_err <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ld_ready   = w_ready;
    assign load_busy  = w_ready;
    assign bank_valid = r_bank_valid;
    assign load_err   = r_load_err;

    bios_bank_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_mem (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(ld_data),
        .i_rd_addr(rd_addr),
        .o_rd_data(rd_data)
    );

endmodule

// File: tb/tb_bios_loadable_bank.sv
// Scoreboard bench for bios_loadable_bank: the driver predicts each cycle's
// outputs from a transaction-level model and queues them; a monitor compares.
module tb_bios_loadable_bank;

    logic        clock;
    logic        reset_n;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        load_start;
    logic        load_abort;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic        bank_valid;
    logic        load_busy;
    logic        load_err;

    typedef struct {
        logic [15:0] data;
        logic        valid;
        logic        err;
        logic        busy;
    } exp_t;

    exp_t expQ[$];

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: a reload is a sequence of 16 accepted words then one checksum.
    logic [15:0] mMem [16];
    logic        mBusy;
    int          mBeats;
    int          mSum;
    logic        mValid;
    logic        mErr;
    logic        mLocked;

    bios_loadable_bank #(.WIDTH(16), .DEPTH(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .load_start(load_start),
        .load_abort(load_abort),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .bank_valid(bank_valid),
        .load_busy (load_busy),
        .load_err  (load_err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mMem[i] = 16'h0000;
        mBusy   = 1'b0;
        mBeats  = 0;
        mSum    = 0;
        mValid  = 1'b1;
        mErr    = 1'b0;
        mLocked = 1'b0;
    endtask

    // One cycle of stimulus: predict this cycle's read, then advance the model.
    task automatic applyStimulus(input logic [3:0] addr, input logic start, input logic abort,
                                 input logic valid, input logic [15:0] data);
        exp_t e;
        @(negedge clock);
        rd_addr    = addr;
        load_start = start;
        load_abort = abort;
        ld_valid   = valid;
        ld_data    = data;
        e.data = mMem[addr];
        if (!mBusy) begin
            if (start && !mLocked) begin
                mBusy  = 1'b1;
                mBeats = 0;
                mSum   = 0;
                mValid = 1'b0;
                mErr   = 1'b0;
            end
        end else if (abort) begin
            mBusy  = 1'b0;
            mErr   = 1'b1;
            mValid = 1'b0;
        end else if (valid) begin
            if (mBeats < 16) begin
                mMem[mBeats] = data;
                mSum = (mSum + int'(data)) % 65536;
                mBeats++;
            end else begin
                mBusy = 1'b0;
                if (int'(data) == mSum) begin
                    mValid = 1'b1;
`ifdef BIOS_LOCK_EN
                    mLocked = 1'b1;
`endif
                end else begin
                    mErr = 1'b1;
                end
            end
        end
        e.valid = mValid;
        e.err   = mErr;
        e.busy  = mBusy;
        expQ.push_back(e);
    endtask

    // Monitor: after every rising edge, pop the prediction for that edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset_n && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("rd_data",    rd_data,           e.data);
                checkOutput("bank_valid", 16'(bank_valid),   16'(e.valid));
                checkOutput("load_err",   16'(load_err),     16'(e.err));
                checkOutput("load_busy",  16'(load_busy),    16'(e.busy));
                checkOutput("ld_ready",   16'(ld_ready),     16'(e.busy));
            end
        end
    end

    task automatic applyReset();
        @(negedge clock);
        reset_n    = 1'b0;
        load_start = 1'b0;
        load_abort = 1'b0;
        ld_valid   = 1'b0;
        modelReset();
        #1;
        checkOutput("reset rd_data",    rd_data,         16'h0000);
        checkOutput("reset bank_valid", 16'(bank_valid), 16'h0001);
        checkOutput("reset load_err",   16'(load_err),   16'h0000);
        checkOutput("reset load_busy",  16'(load_busy),  16'h0000);
        checkOutput("reset ld_ready",   16'(ld_ready),   16'h0000);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic readAll();
        for (int a = 0; a < 16; a++) applyStimulus(4'(a), 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic doLoad(input logic [15:0] words[16], input logic [15:0] cks,
                          input bit throttle, input int strayAt);
        int i;
        int cyc;
        applyStimulus(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0, 16'h0000);
        i   = 0;
        cyc = 0;
        while (i < 16) begin
            logic v;
            v = throttle ? (cyc % 2 == 0) : 1'b1;
            applyStimulus(4'($urandom_range(0, 15)), 1'(cyc == strayAt), 1'b0, v,
                          v ? words[i] : 16'($urandom));
            if (v) i++;
            cyc++;
        end
        applyStimulus(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b1, cks);
    endtask

    // Main sequence: directed reload scenarios followed by a random phase.
    initial begin
        logic [15:0] words[16];
        logic [15:0] goodSum;
        reset_n    = 1'b1;
        rd_addr    = '0;
        load_start = 1'b0;
        load_abort = 1'b0;
        ld_valid   = 1'b0;
        ld_data    = '0;
        modelReset();

        applyReset();
        readAll();

        for (int i = 0; i < 16; i++) words[i] = 16'h1000 + 16'(i);
        doLoad(words, 16'h0078, 1'b0, -1);
        readAll();

        doLoad(words, 16'h0077, 1'b0, -1);
        readAll();

        // Abort coinciding with beat 7: words 0..6 land, word 7 keeps its old value.
        applyStimulus(4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 7; i++) applyStimulus(4'(i), 1'b0, 1'b0, 1'b1, 16'h2000 + 16'(i));
        applyStimulus(4'd7, 1'b0, 1'b1, 1'b1, 16'h2007);
        readAll();

        // Throttled stream with a stray start pulse in the middle.
        goodSum = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            words[i] = 16'($urandom);
            goodSum  = goodSum + words[i];
        end
        doLoad(words, goodSum, 1'b1, 9);
        readAll();

        // Second reload attempt; refused when the bank is locked.
        for (int i = 0; i < 16; i++) words[i] = 16'h3000 + 16'(i);
        doLoad(words, 16'h0078, 1'b0, -1);
        readAll();

        // Reset in the middle of a reload restores the zero image.
        applyReset();
        applyStimulus(4'd0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) applyStimulus(4'(i), 1'b0, 1'b0, 1'b1, 16'h4000 + 16'(i));
        applyReset();
        readAll();

        // Random phase; checksum beats are sometimes forced correct.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (mBusy && mBeats == 16 && $urandom_range(0, 1) == 1) d = 16'(mSum);
            applyStimulus(4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 19) == 0),
                          1'($urandom_range(0, 39) == 0),
                          1'($urandom_range(0, 9) < 7),
                          d);
        end
        readAll();

        applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (4) @(posedge clock);
        #2;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
